// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit sitting beside the E-stage ALU.
//
// Executes mult/multu/div/divu into private HI/LO registers and handles
// mthi/mtlo. Results are computed when the operation is accepted and parked in
// pending registers. They are committed to HI/LO when the busy countdown
// expires, so the architectural registers move only on commit, mthi/mtlo or
// reset.
//
// Handshake: `start` qualifies `mdu_op`. An op is accepted only on a rising
// edge where busy=0. Any start seen while busy=1 is dropped without side
// effects, and that includes the commit edge. The hazard unit stalls on
// busy|start, so a dropped start indicates an upstream bug and not a lost
// instruction.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   start        in   1   E-stage MDU op valid this cycle
//   mdu_op       in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 no-op
//   A            in   32  rs operand (dividend / multiplicand / mthi-mtlo data)
//   B            in   32  rt operand (divisor / multiplier)
//   busy         out  1   registered; high while a mult/div is in flight
//   hi           out  32  architectural HI
//   lo           out  32  architectural LO
//   dbg_state_o  out  1   FSM state (0 IDLE, 1 RUN) for checkers
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbg_state_o
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
    logic          pend_wr_q, pend_wr_d;

    // ---------------- datapath ----------------
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic               div_ovf;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        a_sx   = {{32{A[31]}}, A};
        b_sx   = {{32{B[31]}}, B};
        prod_s = a_sx * b_sx;
        prod_u = {32'b0, A} * {32'b0, B};

        // The divider never sees zero. The B==0 result is thrown away anyway.
        b_safe  = (B == 32'd0) ? 32'd1 : B;
        // INT_MIN / -1 overflows a 32-bit signed quotient. Force the defined answer.
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

        if (div_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end else begin
            quo_s = $signed(A) / $signed(b_safe);   // truncates toward zero
            rem_s = $signed(A) % $signed(b_safe);   // takes the dividend's sign
        end
        quo_u = A / b_safe;
        rem_u = A % b_safe;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_N;
                            state_d   = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_N;
                            state_d   = S_RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                            pend_wr_d = (B != 32'd0);
                            cnt_d     = DIV_N;
                            state_d   = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                            pend_wr_d = (B != 32'd0);
                            cnt_d     = DIV_N;
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // The step from 1 to 0 is the commit edge. <= also guards against a stray 0.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule
